// File: rtl/eq_stream_checker.sv
// Streaming checker for equality results: registers a==b / a!=b for each accepted pair,
// compares against the expected flag, and accumulates pass/fail statistics over an N-vector run.
module eq_stream_checker #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_vec,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_exp_eq,
    output logic             o_valid,
    output logic             o_eq,
    output logic             o_neq,
    output logic             o_pass,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic [CNT_W-1:0] o_first_fail_idx,
    output logic             o_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] w_idx_inc;

    logic             r_s1_valid;
    logic             r_s1_eq;
    logic             r_s1_pass;
    logic [CNT_W-1:0] r_s1_idx;

    logic             r_valid;
    logic             r_eq;
    logic             r_neq;
    logic             r_pass;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_first_fail_idx;
    logic             r_err;

    logic             w_accept;
    logic             w_start_ok;
    logic             w_eq;

    assign w_accept   = i_valid & (r_state == StRun);
    assign w_start_ok = i_start & (r_state != StRun);
    assign w_idx_inc  = r_idx + CntOne;
    assign w_eq       = (i_a == i_b);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_nxt = (i_num_vec != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (w_accept && (w_idx_inc == r_num)) begin
                    w_state_nxt = StDone;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= StIdle;
            r_num            <= '0;
            r_idx            <= '0;
            r_s1_valid       <= 1'b0;
            r_s1_eq          <= 1'b0;
            r_s1_pass        <= 1'b0;
            r_s1_idx         <= '0;
            r_valid          <= 1'b0;
            r_eq             <= 1'b0;
            r_neq            <= 1'b0;
            r_pass           <= 1'b0;
            r_pass_cnt       <= '0;
            r_fail_cnt       <= '0;
            r_first_fail_idx <= '1;
            r_err            <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_eq   <= w_eq;
                r_s1_pass <= (w_eq == i_exp_eq);
                r_s1_idx  <= r_idx;
                r_idx     <= w_idx_inc;
            end

            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_eq   <= r_s1_eq;
                r_neq  <= ~r_s1_eq;
                r_pass <= r_s1_pass;
                if (r_s1_pass) begin
                    if (r_pass_cnt != CntMax) r_pass_cnt <= r_pass_cnt + CntOne;
                end else begin
                    if (r_fail_cnt != CntMax) r_fail_cnt <= r_fail_cnt + CntOne;
                    if (!r_err) r_first_fail_idx <= r_s1_idx;
                    r_err <= 1'b1;
                end
            end

            // A restart overrides any result still draining from the previous run.
            if (w_start_ok) begin
                r_pass_cnt       <= '0;
                r_fail_cnt       <= '0;
                r_first_fail_idx <= '1;
                r_err            <= 1'b0;
                r_idx            <= '0;
                if (i_num_vec != '0) r_num <= i_num_vec;
            end
        end
    end

    assign o_ready          = (r_state == StRun);
    assign o_busy           = (r_state == StRun);
    assign o_done           = (r_state == StDone);
    assign o_valid          = r_valid;
    assign o_eq             = r_eq;
    assign o_neq            = r_neq;
    assign o_pass           = r_pass;
    assign o_pass_cnt       = r_pass_cnt;
    assign o_fail_cnt       = r_fail_cnt;
    assign o_first_fail_idx = r_first_fail_idx;
    assign o_err            = r_err;

endmodule

// File: tb/tb_eq_stream_checker.sv
// Bench for eq_stream_checker: directed runs plus random traffic checked every cycle
// against a transaction-level reference model.
module tb_eq_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n, start, valid, exp_eq;
    logic [7:0] num_vec;
    logic [3:0] a, b;
    logic       o_ready, o_valid, o_eq, o_neq, o_pass, o_busy, o_done, o_err;
    logic [7:0] o_pass_cnt, o_fail_cnt, o_ffi;

    logic       rst2_n, start2, valid2, exp2;
    logic [1:0] num2;
    logic [3:0] a2, b2;
    logic       o2_ready, o2_valid, o2_eq, o2_neq, o2_pass, o2_busy, o2_done, o2_err;
    logic [1:0] o2_pass_cnt, o2_fail_cnt, o2_ffi;

    always #5 clk = ~clk;

    eq_stream_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_vec(num_vec),
        .i_valid(valid), .o_ready(o_ready), .i_a(a), .i_b(b), .i_exp_eq(exp_eq),
        .o_valid(o_valid), .o_eq(o_eq), .o_neq(o_neq), .o_pass(o_pass),
        .o_busy(o_busy), .o_done(o_done), .o_pass_cnt(o_pass_cnt),
        .o_fail_cnt(o_fail_cnt), .o_first_fail_idx(o_ffi), .o_err(o_err)
    );

    eq_stream_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_start(start2), .i_num_vec(num2),
        .i_valid(valid2), .o_ready(o2_ready), .i_a(a2), .i_b(b2), .i_exp_eq(exp2),
        .o_valid(o2_valid), .o_eq(o2_eq), .o_neq(o2_neq), .o_pass(o2_pass),
        .o_busy(o2_busy), .o_done(o2_done), .o_pass_cnt(o2_pass_cnt),
        .o_fail_cnt(o2_fail_cnt), .o_first_fail_idx(o2_ffi), .o_err(o2_err)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: run bookkeeping plus a one-deep queue of results awaiting report.
    bit m_run, m_done, m_err, m_ov, m_eq, m_neq, m_pass;
    int m_idx, m_n, m_pcnt, m_fcnt, m_ffi;
    bit p_valid, p_eq, p_pass, acc;
    int p_idx;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_idx = 0; m_n = 0; m_pcnt = 0; m_fcnt = 0;
            m_ffi = 255; m_err = 0; m_ov = 0; m_eq = 0; m_neq = 0; m_pass = 0; p_valid = 0;
        end else begin
            m_ov = p_valid;
            if (p_valid) begin
                m_eq = p_eq; m_neq = !p_eq; m_pass = p_pass;
                if (p_pass) m_pcnt = (m_pcnt < 255) ? m_pcnt + 1 : 255;
                else begin
                    m_fcnt = (m_fcnt < 255) ? m_fcnt + 1 : 255;
                    if (!m_err) m_ffi = p_idx;
                    m_err = 1;
                end
            end
            acc = m_run && valid;
            p_valid = acc;
            if (acc) begin
                p_eq = (a == b); p_pass = ((a == b) == exp_eq); p_idx = m_idx;
                m_idx++;
                if (m_idx == m_n) begin m_run = 0; m_done = 1; end
            end else if (!m_run && start) begin
                m_pcnt = 0; m_fcnt = 0; m_err = 0; m_ffi = 255; m_idx = 0;
                if (num_vec != 0) begin m_run = 1; m_done = 0; m_n = int'(num_vec); end
                else begin m_run = 0; m_done = 1; end
            end
        end
    end

    bit       chk_en = 0;
    int       n_pulse = 0;
    bit [7:0] seq = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", o_ready, m_run);
            chk("busy", o_busy, m_run);
            chk("done", o_done, m_done);
            chk("out_valid", o_valid, m_ov);
            chk("out_eq", o_eq, m_eq);
            chk("out_neq", o_neq, m_neq);
            chk("out_pass", o_pass, m_pass);
            chk("pass_cnt", o_pass_cnt, m_pcnt);
            chk("fail_cnt", o_fail_cnt, m_fcnt);
            chk("first_fail_idx", o_ffi, m_ffi);
            chk("err", o_err, m_err);
            if (o_valid === 1'b1) begin
                n_pulse++;
                seq = {seq[6:0], o_eq};
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] ia, input logic [3:0] ib, input bit e);
        valid = v; a = ia; b = ib; exp_eq = e;
    endtask

    task automatic drive2(input bit v, input logic [3:0] ia, input logic [3:0] ib, input bit e);
        valid2 = v; a2 = ia; b2 = ib; exp2 = e;
    endtask

    logic [3:0] pa [8] = '{4'd1, 4'd0, 4'd7, 4'd5, 4'd8, 4'd9, 4'd15, 4'd0};
    logic [3:0] pb [8] = '{4'd1, 4'd4, 4'd3, 4'd5, 4'd2, 4'd9, 4'd0,  4'd0};
    bit         pe [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 0; start = 0; num_vec = '0; drive(0, 0, 0, 0);
        rst2_n = 0; start2 = 0; num2 = '0; drive2(0, 0, 0, 0);
        tick(); tick();
        rst_n = 1; rst2_n = 1;
        chk_en = 1;
        chk("reset ffi", o_ffi, 32'hFF);
        chk("reset ready", o_ready, 0);

        // Abort a run with a reset after two accepts.
        start = 1; num_vec = 8'd5; tick(); start = 0;
        drive(1, 1, 1, 1); tick();
        drive(1, 2, 2, 1); tick();
        drive(0, 0, 0, 0); rst_n = 0; tick(); rst_n = 1;
        chk("abort pass_cnt", o_pass_cnt, 0);
        chk("abort ffi", o_ffi, 32'hFF);
        chk("abort ready", o_ready, 0);
        tick(); tick();

        // Eight passing vectors.
        n_pulse = 0; seq = '0;
        start = 1; num_vec = 8'd8; tick(); start = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, pa[i], pb[i], pe[i]); tick();
        end
        drive(0, 0, 0, 0); tick(); tick(); tick();
        chk("run8 pulses", n_pulse, 8);
        chk("run8 eq sequence", seq, 32'h95);
        chk("run8 pass_cnt", o_pass_cnt, 8);
        chk("run8 fail_cnt", o_fail_cnt, 0);
        chk("run8 done", o_done, 1);

        // Wrong expectations on idx0 and idx2.
        start = 1; num_vec = 8'd3; tick(); start = 0;
        drive(1, 3, 3, 0); tick();
        drive(1, 2, 6, 0); tick();
        drive(1, 4, 4, 0); tick();
        drive(0, 0, 0, 0); tick(); tick(); tick();
        chk("run3 fail_cnt", o_fail_cnt, 2);
        chk("run3 pass_cnt", o_pass_cnt, 1);
        chk("run3 ffi", o_ffi, 0);
        chk("run3 err", o_err, 1);

        // Stalled input: valid toggles 1,0,1,0.
        n_pulse = 0;
        start = 1; num_vec = 8'd2; tick(); start = 0;
        drive(1, 5, 5, 1); tick();
        drive(0, 0, 0, 0); tick();
        drive(1, 6, 6, 1); tick();
        drive(0, 0, 0, 0); tick(); tick(); tick();
        chk("stall pulses", n_pulse, 2);
        chk("stall done", o_done, 1);
        chk("stall ready", o_ready, 0);

        // Empty run, then a run with start pulsed mid-way.
        start = 1; num_vec = 8'd0; tick(); start = 0;
        chk("empty done", o_done, 1);
        chk("empty pass_cnt", o_pass_cnt, 0);
        chk("empty err", o_err, 0);
        start = 1; num_vec = 8'd3; tick(); start = 0;
        drive(1, 1, 1, 1); tick();
        drive(1, 1, 1, 1); start = 1; num_vec = 8'd7; tick(); start = 0;
        drive(1, 1, 1, 1); tick();
        drive(0, 0, 0, 0); tick(); tick(); tick();
        chk("ignore start pass_cnt", o_pass_cnt, 3);
        chk("ignore start done", o_done, 1);

        // Two-bit counters: three failing vectors then a restart.
        start2 = 1; num2 = 2'd3; tick(); start2 = 0;
        drive2(1, 1, 2, 1); tick();
        drive2(1, 3, 3, 0); tick();
        drive2(1, 0, 15, 1); tick();
        drive2(0, 0, 0, 0); tick(); tick(); tick();
        chk("cnt2 fail_cnt", o2_fail_cnt, 3);
        chk("cnt2 ffi", o2_ffi, 0);
        chk("cnt2 err", o2_err, 1);
        start2 = 1; num2 = 2'd1; tick(); start2 = 0;
        chk("cnt2 restart fail_cnt", o2_fail_cnt, 0);
        chk("cnt2 restart ffi", o2_ffi, 3);
        chk("cnt2 restart err", o2_err, 0);
        drive2(1, 6, 6, 1); tick();
        drive2(0, 0, 0, 0); tick(); tick(); tick();
        chk("cnt2 restart pass_cnt", o2_pass_cnt, 1);

        // Random traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            start   = ($urandom_range(0, 15) == 0);
            num_vec = 8'($urandom_range(0, 12));
            valid   = ($urandom_range(0, 3) != 0);
            a       = 4'($urandom);
            b       = ($urandom_range(0, 1) != 0) ? a : 4'($urandom);
            exp_eq  = ($urandom_range(0, 3) != 0) ? (a == b) : (a != b);
            tick();
        end
        rst_n = 1; start = 0; valid = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
